video_pattern_tx: RTL and testbench

- Source end of the pixel-stream interface (pclk / hs / vs / de / 16-bit RGB565 data) that the OSD and sobel blocks consume.
- Generates VGA-style sync timing from parameterised horizontal and vertical counters.
- Drives a selectable test pattern, plus the pixel x/y coordinates, aligned with de.
- Used as a camera/SDRAM stand-in for bench and board bring-up of downstream overlay blocks.

---
 rtl/video_pattern_tx.sv | 193 +++++++++++++++++++
 tb/tb_video_pattern_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_tx.sv
// video_pattern_tx: VGA-style pixel-stream source with selectable test patterns.
// Horizontal/vertical counters generate sync timing; every output is registered
// one pclk after the counters. Optional build macro VIDEO_PATTERN_TX_BORDER_EN
// forces a white one-pixel frame border over any pattern.
module video_pattern_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [15:0] o_data,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        frame_start
);

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [11:0] H_ACT        = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT        = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
  localparam logic [11:0] BAR_LAST     = 12'(BAR_W - 1);
`ifdef VIDEO_PATTERN_TX_BORDER_EN
  localparam logic [11:0] H_ACT_LAST   = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_ACT_LAST   = 12'(V_ACTIVE - 1);
`endif

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0: bar_color = 16'hFFFF;
      3'd1: bar_color = 16'hFFE0;
      3'd2: bar_color = 16'h07FF;
      3'd3: bar_color = 16'h07E0;
      3'd4: bar_color = 16'hF81F;
      3'd5: bar_color = 16'hF800;
      3'd6: bar_color = 16'h001F;
      3'd7: bar_color = 16'h0000;
    endcase
  endfunction

  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [11:0] bar_px_q, bar_px_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] solid_q, solid_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [15:0] data_q, data_d;
  logic [11:0] x_q, x_d, y_q, y_d;

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
    end
  end

  // Running colour-bar counter tracking h_cnt, so no divider is needed.
  always_comb begin
    bar_idx_d = bar_idx_q;
    bar_px_d  = bar_px_q;
    if (h_cnt_q == H_LAST) begin
      bar_idx_d = '0;
      bar_px_d  = '0;
    end else if (h_cnt_q < H_ACT) begin
      if (bar_px_q == BAR_LAST) begin
        // Columns past 8*BAR_W stay parked in the last bar.
        if (bar_idx_q != 3'd7) begin
          bar_idx_d = bar_idx_q + 3'd1;
          bar_px_d  = '0;
        end
      end else begin
        bar_px_d = bar_px_q + 12'd1;
      end
    end
  end

  // Pattern shadow and next-output computation for the current raster position.
  always_comb begin
    logic        frame_origin;
    logic [1:0]  sel_eff;
    logic [15:0] solid_eff;
    logic [15:0] pat;

    // At the frame origin the live inputs are used directly, so the first
    // pixel of a frame already shows the newly captured pattern.
    frame_origin = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    sel_eff      = frame_origin ? pattern_sel : sel_q;
    solid_eff    = frame_origin ? solid_color : solid_q;
    sel_d        = sel_eff;
    solid_d      = solid_eff;

    de_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_d = ((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END)) ? HS_ON : ~HS_ON;
    vs_d = ((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END)) ? VS_ON : ~VS_ON;

    pat = '0;
    case (pattern_e'(sel_eff))
      PAT_BARS:  pat = bar_color(bar_idx_q);
      PAT_GRAD:  pat = {h_cnt_q[8:4], v_cnt_q[8:3], h_cnt_q[8:4]};
      PAT_CHECK: pat = (h_cnt_q[5] ^ v_cnt_q[5]) ? 16'hFFFF : 16'h0000;
      PAT_SOLID: pat = solid_eff;
    endcase

`ifdef VIDEO_PATTERN_TX_BORDER_EN
    if ((h_cnt_q == 12'd0) || (h_cnt_q == H_ACT_LAST) ||
        (v_cnt_q == 12'd0) || (v_cnt_q == V_ACT_LAST)) begin
      pat = 16'hFFFF;
    end
`endif

    data_d = de_d ? pat : 16'h0000;
    x_d    = de_d ? h_cnt_q : 12'd0;
    y_d    = de_d ? v_cnt_q : 12'd0;
    fs_d   = de_d && frame_origin;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_idx_q <= '0;
      bar_px_q  <= '0;
      sel_q     <= PAT_BARS;
      solid_q   <= 16'h0000;
      hs_q      <= ~HS_ON;
      vs_q      <= ~VS_ON;
      de_q      <= 1'b0;
      data_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_idx_q <= bar_idx_d;
      bar_px_q  <= bar_px_d;
      sel_q     <= sel_d;
      solid_q   <= solid_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      data_q    <= data_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
    end
  end

  assign o_hs        = hs_q;
  assign o_vs        = vs_q;
  assign o_de        = de_q;
  assign o_data      = data_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_tx.sv
// Testbench for video_pattern_tx using a reduced raster so several frames fit
// in a short run. A position-in-frame reference model checks every output on
// every cycle; a vector table and hand sequences cover the corner cases.
module tb_video_pattern_tx;

  localparam int HA = 66, HFP = 2, HSW = 6, HBP = 2;
  localparam int VA = 40, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int BAR_W = HA / 8;
  localparam logic HS_ON = 1'b0;
  localparam logic VS_ON = 1'b1;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        o_hs, o_vs, o_de, frame_start;
  logic [15:0] o_data;
  logic [11:0] o_x, o_y;

  video_pattern_tx #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(0), .VS_POL(1)
  ) dut (
    .pclk(pclk), .rst(rst), .pattern_sel(pattern_sel), .solid_color(solid_color),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data),
    .o_x(o_x), .o_y(o_y), .frame_start(frame_start)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] data;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
  } vid_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] solid;
    int          x;
    int          y;
    logic [15:0] exp;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          pos = 0;
  logic [1:0]  sh_sel = 2'd0;
  logic [15:0] sh_solid = 16'h0000;
  vid_t        exp_o, got_o;
  vec_t        tbl[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] bar_ref(input int b);
    case (b)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic is_border(input int h, input int v);
`ifdef VIDEO_PATTERN_TX_BORDER_EN
    return (h == 0) || (h == HA - 1) || (v == 0) || (v == VA - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Expected output for raster position (h,v), straight from the pixel rules.
  function automatic vid_t ref_pixel(input int h, input int v,
                                     input logic [1:0] sel, input logic [15:0] solid);
    vid_t r;
    logic [11:0] xv, yv;
    int bar;
    xv = 12'(h);
    yv = 12'(v);
    r = '0;
    r.de = (h < HA) && (v < VA);
    r.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HS_ON : ~HS_ON;
    r.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VS_ON : ~VS_ON;
    if (r.de) begin
      r.x  = xv;
      r.y  = yv;
      r.fs = (h == 0) && (v == 0);
      case (sel)
        2'd0: begin
          bar = h / BAR_W;
          if (bar > 7) bar = 7;
          r.data = bar_ref(bar);
        end
        2'd1: r.data = {xv[8:4], yv[8:3], xv[8:4]};
        2'd2: r.data = (xv[5] ^ yv[5]) ? 16'hFFFF : 16'h0000;
        default: r.data = solid;
      endcase
      if (is_border(h, v)) r.data = 16'hFFFF;
    end
    return r;
  endfunction

  // One pclk: advance the model with the inputs the DUT sampled, then compare.
  task automatic tick();
    @(posedge pclk);
    if (rst) begin
      exp_o    = '0;
      exp_o.hs = ~HS_ON;
      exp_o.vs = ~VS_ON;
      pos      = 0;
      sh_sel   = 2'd0;
      sh_solid = 16'h0000;
    end else begin
      if (pos == 0) begin
        sh_sel   = pattern_sel;
        sh_solid = solid_color;
      end
      exp_o = ref_pixel(pos % HT, pos / HT, sh_sel, sh_solid);
      pos   = (pos + 1) % FRAME;
    end
    #1;
    cyc++;
    got_o = {o_hs, o_vs, o_de, o_data, o_x, o_y, frame_start};
    check("stream", {20'd0, got_o}, {20'd0, exp_o});
  endtask

  // Advance at least one cycle until the model emits active pixel (x,y).
  task automatic run_to(input int x, input int y);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(exp_o.de && int'(exp_o.x) == x && int'(exp_o.y) == y) && n <= 2 * FRAME);
    if (n > 2 * FRAME) begin
      vectors++;
      miscompares++;
      $display("FAIL run_to(%0d,%0d) not reached within %0d cycles", x, y, 2 * FRAME);
    end
  endtask

  initial begin
    int de_cnt, hs_cnt, vs_cnt, hs_first, vs_first;
    logic [1:0]  cur_sel;
    logic [15:0] cur_solid;
    logic        have_cur;
    logic [15:0] want;

    // Reset state, then the first pixel after release.
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {20'd0, got_o}, {20'd0, 1'b1, 1'b0, 42'd0});
    rst = 1'b0;
    tick();
    check("first_pixel", {60'd0, o_de, o_x == 12'd0, o_y == 12'd0, frame_start}, 64'hF);

    // Frame timing measured over exactly one frame starting at frame_start.
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; hs_first = -1; vs_first = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) tick();
      if (o_de) de_cnt++;
      if (o_hs == HS_ON) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
      if (o_vs == VS_ON) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = i;
      end
    end
    tick();
    check("frame_period", 64'(frame_start), 64'd1);
    check("de_count", 64'(de_cnt), 64'(HA * VA));
    check("hs_count", 64'(hs_cnt), 64'(HSW * VT));
    check("vs_count", 64'(vs_cnt), 64'(VSW * HT));
    check("hs_offset", 64'(hs_first), 64'(HA + HFP));
    check("vs_offset", 64'(vs_first), 64'((VA + VFP) * HT));

    // Pattern vectors; border pixels are promoted to white when the border build is on.
    tbl.push_back('{2'd0, 16'h0000,  0, 3, 16'hFFFF});
    tbl.push_back('{2'd0, 16'h0000,  7, 3, 16'hFFFF});
    tbl.push_back('{2'd0, 16'h0000,  8, 3, 16'hFFE0});
    tbl.push_back('{2'd0, 16'h0000, 16, 3, 16'h07FF});
    tbl.push_back('{2'd0, 16'h0000, 24, 3, 16'h07E0});
    tbl.push_back('{2'd0, 16'h0000, 32, 3, 16'hF81F});
    tbl.push_back('{2'd0, 16'h0000, 40, 3, 16'hF800});
    tbl.push_back('{2'd0, 16'h0000, 48, 3, 16'h001F});
    tbl.push_back('{2'd0, 16'h0000, 63, 3, 16'h0000});
    tbl.push_back('{2'd0, 16'h0000, 65, 3, 16'h0000});
    tbl.push_back('{2'd2, 16'h0000, 31, 0, 16'h0000});
    tbl.push_back('{2'd2, 16'h0000, 32, 0, 16'hFFFF});
    tbl.push_back('{2'd2, 16'h0000,  0, 32, 16'hFFFF});
    tbl.push_back('{2'd2, 16'h0000, 32, 32, 16'h0000});
    tbl.push_back('{2'd1, 16'h0000, 16, 8, 16'h0821});
    tbl.push_back('{2'd1, 16'h0000, 63, 39, 16'h1883});
    tbl.push_back('{2'd3, 16'h1234,  5, 5, 16'h1234});
    tbl.push_back('{2'd3, 16'h0000,  5, 0, 16'h0000});
    tbl.push_back('{2'd3, 16'h0000,  0, 5, 16'h0000});
    tbl.push_back('{2'd3, 16'h0000,  5, 5, 16'h0000});
    tbl.push_back('{2'd3, 16'h0000, 65, 5, 16'h0000});
    tbl.push_back('{2'd3, 16'h0000,  5, 39, 16'h0000});

    have_cur = 1'b0; cur_sel = 2'd0; cur_solid = 16'h0000;
    foreach (tbl[i]) begin
      if (!have_cur || tbl[i].sel != cur_sel || tbl[i].solid != cur_solid) begin
        pattern_sel = tbl[i].sel;
        solid_color = tbl[i].solid;
        cur_sel = tbl[i].sel;
        cur_solid = tbl[i].solid;
        have_cur = 1'b1;
        run_to(0, 0);
      end
      run_to(tbl[i].x, tbl[i].y);
      want = is_border(tbl[i].x, tbl[i].y) ? 16'hFFFF : tbl[i].exp;
      check($sformatf("table[%0d]", i), {16'd0, o_x, o_y, o_data, 8'd0},
            {16'd0, 12'(tbl[i].x), 12'(tbl[i].y), want, 8'd0});
    end

    // Mid-frame pattern change takes effect only at the next frame.
    pattern_sel = 2'd0;
    solid_color = 16'h0000;
    run_to(0, 0);
    run_to(1, 10);
    pattern_sel = 2'd3;
    solid_color = 16'h1234;
    run_to(40, 20);
    check("latch_hold", 64'(o_data), 64'hF800);
    run_to(0, 0);
    check("latch_next_first", {44'd0, o_data, o_de, frame_start, 2'd0}, {44'd0, is_border(0, 0) ? 16'hFFFF : 16'h1234, 1'b1, 1'b1, 2'd0});
    run_to(20, 20);
    check("latch_solid", 64'(o_data), 64'h1234);

    // Reset in the middle of a frame.
    run_to(30, 20);
    rst = 1'b1;
    repeat (3) begin
      tick();
      check("rst_hold", {20'd0, got_o}, {20'd0, 1'b1, 1'b0, 42'd0});
    end
    rst = 1'b0;
    tick();
    check("rst_restart", {60'd0, o_de, o_x == 12'd0, o_y == 12'd0, frame_start}, 64'hF);

    // Randomised pattern changes and occasional short resets over a few frames.
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        pattern_sel = 2'($urandom_range(0, 3));
        solid_color = 16'($urandom);
      end
      if (!rst && $urandom_range(0, 4999) == 0) rst = 1'b1;
      else if (rst && $urandom_range(0, 2) == 0) rst = 1'b0;
      tick();
    end
    rst = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
